// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer: relative branches/jumps, absolute jumps, CALL/RET via a circular RAS.
// Optional macro PC_SEQ_BRANCH_STATS_EN adds a 16-bit saturating count of taken redirects on taken_count.
module pc_sequencer #(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  localparam int unsigned      PTR_W     = $clog2(RAS_DEPTH),
  localparam int unsigned      CNT_W     = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic              stall,
  input  logic [15:0]       opcode,
  input  logic              n,
  input  logic              z,
  input  logic              p,
  input  logic [ADDR_W-1:0] imm,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              taken,
  output logic [CNT_W-1:0]  ras_count,
  output logic              ras_ovf,
  output logic              ras_unf,
  output logic [15:0]       taken_count
);

  localparam logic [3:0] OP_BR   = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_JMPA = 4'hE;
  localparam logic [3:0] OP_STK  = 4'hF;

  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [PTR_W-1:0]  top;
  logic              accept;
  logic [3:0]        op;
  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] rel_target;
  logic [ADDR_W-1:0] next_pc;
  logic              next_taken;
  logic              cond;
  logic              full;
  logic              push;
  logic              pop;
  logic              unf_set;

  // State register: PC, taken pulse, RAS pointer/count and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      taken     <= 1'b0;
      top       <= '0;
      ras_count <= '0;
      ras_ovf   <= 1'b0;
      ras_unf   <= 1'b0;
    end else if (accept) begin
      pc    <= next_pc;
      taken <= next_taken;
      if (push) begin
        top <= top + PTR_W'(1);
        if (full) ras_ovf <= 1'b1;
        else      ras_count <= ras_count + CNT_W'(1);
      end else if (pop) begin
        top       <= top - PTR_W'(1);
        ras_count <= ras_count - CNT_W'(1);
      end
      if (unf_set) ras_unf <= 1'b1;
    end else begin
      taken <= 1'b0;
    end
  end

  // RAS storage has no reset; a push when full overwrites the oldest slot
  always_ff @(posedge clk) begin
    if (rst_n && accept && push) ras[top] <= pc_plus1;
  end

  // Next-PC and RAS action selection
  always_comb begin
    next_pc    = pc_plus1;
    next_taken = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    unf_set    = 1'b0;
    op         = opcode[15:12];
    off        = {{(ADDR_W-8){opcode[7]}}, opcode[7:0]};
    rel_target = opcode[8] ? (pc + off) : (pc - off);
    cond       = (opcode[11] & n) | (opcode[10] & z) | (opcode[9] & p);
    full       = (ras_count == CNT_W'(RAS_DEPTH));
    case (op)
      OP_BR: begin
        if (cond) begin
          next_pc    = rel_target;
          next_taken = 1'b1;
        end
      end
      OP_JMP: begin
        next_pc    = rel_target;
        next_taken = 1'b1;
      end
      OP_JMPA: begin
        next_pc    = imm;
        next_taken = 1'b1;
      end
      OP_STK: begin
        if (!opcode[11]) begin
          push       = 1'b1;
          next_pc    = imm;
          next_taken = 1'b1;
        end else if (ras_count != '0) begin
          pop        = 1'b1;
          next_pc    = ras[top - PTR_W'(1)];
          next_taken = 1'b1;
        end else begin
          unf_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Combinational outputs
  always_comb begin
    accept   = instr_valid & ~stall;
    pc_plus1 = pc + ADDR_W'(1);
  end

`ifdef PC_SEQ_BRANCH_STATS_EN
  // Counts on the same edge that raises taken, saturating at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taken_count <= 16'h0000;
    end else if (accept && next_taken && (taken_count != 16'hFFFF)) begin
      taken_count <= taken_count + 16'd1;
    end
  end
`else
  assign taken_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a behavioural model pushes expected state per step, popped and checked after each edge.
module tb_pc_sequencer;

  typedef struct packed {
    logic [15:0] pc;
    logic        taken;
    logic [3:0]  cnt;
    logic        ovf;
    logic        unf;
    logic [15:0] tc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] opcode = 16'h0000;
  logic        n = 1'b0;
  logic        z = 1'b0;
  logic        p = 1'b0;
  logic [15:0] imm = 16'h0000;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic        taken;
  logic [3:0]  ras_count;
  logic        ras_ovf;
  logic        ras_unf;
  logic [15:0] taken_count;

  int checks = 0;
  int failures = 0;

  exp_t        sb[$];
  logic [15:0] stk[$];
  logic [15:0] m_pc = 16'h0000;
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;
  logic [15:0] m_tc = 16'h0000;

  pc_sequencer #(.ADDR_W(16), .RAS_DEPTH(8), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .stall(stall),
    .opcode(opcode), .n(n), .z(z), .p(p), .imm(imm),
    .pc(pc), .pc_plus1(pc_plus1), .taken(taken), .ras_count(ras_count),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait one edge, then pop the oldest expectation and compare every output
  task automatic settle_and_compare(input string tag);
    exp_t        e;
    logic [15:0] e_p1;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "/scoreboard_empty"}, 32'd1, 32'd0);
      return;
    end
    e    = sb.pop_front();
    e_p1 = e.pc + 16'd1;
    chk({tag, "/pc"},          32'(pc),          32'(e.pc));
    chk({tag, "/pc_plus1"},    32'(pc_plus1),    32'(e_p1));
    chk({tag, "/taken"},       32'(taken),       32'(e.taken));
    chk({tag, "/ras_count"},   32'(ras_count),   32'(e.cnt));
    chk({tag, "/ras_ovf"},     32'(ras_ovf),     32'(e.ovf));
    chk({tag, "/ras_unf"},     32'(ras_unf),     32'(e.unf));
    chk({tag, "/taken_count"}, 32'(taken_count), 32'(e.tc));
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0; instr_valid = 1'b1; stall = 1'b0; opcode = 16'hD005;
    {n, z, p} = 3'b111; imm = 16'h5555;
    m_pc = 16'h0000; m_ovf = 1'b0; m_unf = 1'b0; m_tc = 16'h0000;
    stk.delete();
    sb.push_back('{pc: m_pc, taken: 1'b0, cnt: 4'd0, ovf: 1'b0, unf: 1'b0, tc: 16'h0000});
    settle_and_compare(tag);
  endtask

  task automatic step(input string tag, input logic v, input logic s, input logic [15:0] op,
                      input logic [2:0] nzp, input logic [15:0] im);
    logic [15:0] off;
    logic [15:0] rel;
    logic [15:0] nxt;
    logic        tk;
    rst_n = 1'b1; instr_valid = v; stall = s; opcode = op; {n, z, p} = nzp; imm = im;
    off = {{8{op[7]}}, op[7:0]};
    rel = op[8] ? m_pc + off : m_pc - off;
    nxt = m_pc + 16'd1;
    tk  = 1'b0;
    if (v && !s) begin
      if (op[15:12] == 4'hC) begin
        if ((op[11] & nzp[2]) | (op[10] & nzp[1]) | (op[9] & nzp[0])) begin
          nxt = rel; tk = 1'b1;
        end
      end else if (op[15:12] == 4'hD) begin
        nxt = rel; tk = 1'b1;
      end else if (op[15:12] == 4'hE) begin
        nxt = im; tk = 1'b1;
      end else if (op[15:12] == 4'hF) begin
        if (!op[11]) begin
          if (stk.size() == 8) begin
            void'(stk.pop_front());
            m_ovf = 1'b1;
          end
          stk.push_back(m_pc + 16'd1);
          nxt = im; tk = 1'b1;
        end else if (stk.size() > 0) begin
          nxt = stk.pop_back(); tk = 1'b1;
        end else begin
          m_unf = 1'b1;
        end
      end
      m_pc = nxt;
    end
`ifdef PC_SEQ_BRANCH_STATS_EN
    if (tk && (m_tc != 16'hFFFF)) m_tc = m_tc + 16'd1;
`endif
    sb.push_back('{pc: m_pc, taken: tk, cnt: 4'(stk.size()), ovf: m_ovf, unf: m_unf, tc: m_tc});
    settle_and_compare(tag);
  endtask

  initial begin
    // Reset held two cycles while a JMP is presented
    do_reset("reset0");
    do_reset("reset1");
    chk("reset_pc_const", 32'(pc), 32'h0);

    // Branches from 0x0010
    step("jmpa_10", 1, 0, 16'hE000, 3'b000, 16'h0010);
    step("br_fwd_taken", 1, 0, 16'hC903, 3'b100, 16'h0000);
    chk("br_fwd_const", 32'(pc), 32'h0013);
    step("br_not_taken", 1, 0, 16'hC903, 3'b010, 16'h0000);
    chk("br_nt_const", 32'(pc), 32'h0014);
    step("br_neg_off", 1, 0, 16'hCBFE, 3'b100, 16'h0000);
    chk("br_neg_const", 32'(pc), 32'h0012);
    step("br_bwd_dir0", 1, 0, 16'hC404, 3'b010, 16'h0000);
    step("br_nzp_zero", 1, 0, 16'hC105, 3'b111, 16'h0000);
    step("other_op", 1, 0, 16'h1234, 3'b111, 16'h7777);
    step("invalid", 0, 0, 16'hE000, 3'b000, 16'h4321);

    // Stall holds PC and blocks RAS updates
    step("jmpa_20", 1, 0, 16'hE000, 3'b000, 16'h0020);
    for (int i = 0; i < 3; i++) step("stall_jmpa", 1, 1, 16'hE000, 3'b000, 16'h1234);
    step("stall_call", 1, 1, 16'hF000, 3'b000, 16'h0999);
    step("stall_ret", 1, 1, 16'hF800, 3'b000, 16'h0000);
    step("unstall", 1, 0, 16'hE000, 3'b000, 16'h1234);
    chk("unstall_const", 32'(pc), 32'h1234);

    // Nested CALL/RET
    step("jmpa_05", 1, 0, 16'hE000, 3'b000, 16'h0005);
    step("call1", 1, 0, 16'hF000, 3'b000, 16'h0100);
    step("call2", 1, 0, 16'hF000, 3'b000, 16'h0200);
    step("ret1", 1, 0, 16'hF800, 3'b000, 16'h0000);
    chk("ret1_const", 32'(pc), 32'h0101);
    step("ret2", 1, 0, 16'hF800, 3'b000, 16'h0000);
    chk("ret2_const", 32'(pc), 32'h0006);

    // RAS overflow and underflow
    for (int i = 0; i < 9; i++) step("call_fill", 1, 0, 16'hF000, 3'b000, 16'(16'h1000 + i * 16'h10));
    chk("ovf_const", 32'(ras_ovf), 32'd1);
    for (int i = 0; i < 8; i++) step("ret_drain", 1, 0, 16'hF800, 3'b000, 16'h0000);
    step("ret_underflow", 1, 0, 16'hF800, 3'b000, 16'h0000);
    chk("unf_taken_const", 32'(taken), 32'd0);
    step("after_unf", 1, 0, 16'h0000, 3'b000, 16'h0000);

    // Reset overrides an accepted CALL and clears sticky flags
    rst_n = 1'b0; instr_valid = 1'b1; opcode = 16'hF000; imm = 16'h0ABC;
    m_pc = 16'h0000; m_ovf = 1'b0; m_unf = 1'b0; m_tc = 16'h0000; stk.delete();
    sb.push_back('{pc: 16'h0000, taken: 1'b0, cnt: 4'd0, ovf: 1'b0, unf: 1'b0, tc: 16'h0000});
    settle_and_compare("reset_mid_call");

    // Wrap-around in both directions
    step("jmpa_ffff", 1, 0, 16'hE000, 3'b000, 16'hFFFF);
    step("wrap_fwd", 1, 0, 16'hD101, 3'b000, 16'h0000);
    chk("wrap_fwd_const", 32'(pc), 32'h0000);
    step("wrap_bwd", 1, 0, 16'hD001, 3'b000, 16'h0000);
    chk("wrap_bwd_const", 32'(pc), 32'hFFFF);

`ifdef PC_SEQ_BRANCH_STATS_EN
    for (int i = 0; i < 70000; i++) step("stats_jmp", 1, 0, 16'hD101, 3'b000, 16'h0000);
    chk("stats_sat_const", 32'(taken_count), 32'hFFFF);
`else
    for (int i = 0; i < 20; i++) step("stats_jmp", 1, 0, 16'hD101, 3'b000, 16'h0000);
    chk("stats_off_const", 32'(taken_count), 32'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
